// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery charger controller.
//   state_t              : FSM state encodings, also driven on the 'state' port
//   DEFAULT_SAMPLE_DIV   : clock cycles between an ADC acknowledge and the next request
//   DEFAULT_DEB          : consecutive qualifying samples needed for a threshold transition
//   DEFAULT_HYST         : recharge hysteresis, in vbat codes below vcutoff
package batcharger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_TC    = 3'b001,
        ST_CC    = 3'b010,
        ST_CV    = 3'b011,
        ST_DONE  = 3'b100,
        ST_FAULT = 3'b101
    } state_t;

    localparam int DEFAULT_SAMPLE_DIV = 1000;
    localparam int DEFAULT_DEB        = 2;
    localparam int DEFAULT_HYST       = 10;

endpackage

// File: rtl/batcharger_sampler.sv
// ADC sample timer and request/acknowledge handshake.
//   clk, rst     : clock, asynchronous active-high reset
//   run          : sampler enable; low clears the timer and withdraws the request
//   vbat, ibat   : ADC result codes, valid while adc_ack is high
//   adc_ack      : one-cycle conversion-done pulse from the ADC
//   adc_req      : conversion request, held until acknowledged
//   sample_valid : high in the cycle a requested conversion is acknowledged
//   vbat_s/ibat_s: sample data; live ADC value during sample_valid, last capture otherwise
module batcharger_sampler
    import batcharger_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic       adc_ack,
    output logic       adc_req,
    output logic       sample_valid,
    output logic [7:0] vbat_s,
    output logic [7:0] ibat_s
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [7:0]    vbat_q;
    logic [7:0]    ibat_q;

    // An acknowledge only counts while a request is outstanding.
    assign sample_valid = run && adc_req && adc_ack;

    // Bypass the capture registers in the acknowledge cycle so the FSM can
    // register its decision on that same edge.
    assign vbat_s = sample_valid ? vbat : vbat_q;
    assign ibat_s = sample_valid ? ibat : ibat_q;

    // NOTE: the sample registers are reset along with the control state so a
    // read-back after reset never exposes stale conversion data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            adc_req <= 1'b0;
            vbat_q  <= '0;
            ibat_q  <= '0;
        end else if (!run) begin
            div_cnt <= '0;
            adc_req <= 1'b0;
        end else if (adc_req) begin
            if (adc_ack) begin
                adc_req <= 1'b0;
                vbat_q  <= vbat;
                ibat_q  <= ibat;
            end
        end else if (div_cnt == CW'(SAMPLE_DIV - 1)) begin
            // Counter is left at zero so it restarts cleanly after the ack.
            adc_req <= 1'b1;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/batcharger_ctrl.sv
// Battery charger controller: trickle (TC) -> constant current (CC) ->
// constant voltage (CV) -> DONE, with recharge from DONE and a charge timeout.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : charger enable; low forces IDLE
//   vbat, ibat          : ADC codes, valid with adc_ack
//   vtok, vcutoff, iend : voltage/current thresholds
//   tmax                : timeout in samples (0 disables)
//   adc_req / adc_ack   : ADC handshake
//   cc, tc, cv          : one-hot mode enables to the power stage
//   done, fault         : charge complete / timeout fault
//   state               : current FSM state encoding
module batcharger_ctrl
    import batcharger_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int DEB        = DEFAULT_DEB,
    parameter int HYST       = DEFAULT_HYST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  vbat,
    input  logic [7:0]  ibat,
    input  logic [7:0]  vtok,
    input  logic [7:0]  vcutoff,
    input  logic [7:0]  iend,
    input  logic [15:0] tmax,
    output logic        adc_req,
    input  logic        adc_ack,
    output logic        cc,
    output logic        tc,
    output logic        cv,
    output logic        done,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int          DW     = (DEB > 0) ? $clog2(DEB + 1) : 1;
    localparam logic [7:0]  HYST_C = 8'(HYST);

    state_t          cur, nxt, target;
    logic [DW-1:0]   deb_q, deb_d;
    logic [15:0]     tmr_q, tmr_d;
    logic            qual;
    logic            charging;
    logic            sample_valid;
    logic [7:0]      vbat_s, ibat_s;

    batcharger_sampler #(.SAMPLE_DIV(SAMPLE_DIV)) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .run          (en),
        .vbat         (vbat),
        .ibat         (ibat),
        .adc_ack      (adc_ack),
        .adc_req      (adc_req),
        .sample_valid (sample_valid),
        .vbat_s       (vbat_s),
        .ibat_s       (ibat_s)
    );

    assign charging = (cur == ST_TC) || (cur == ST_CC) || (cur == ST_CV);

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        nxt    = cur;
        deb_d  = deb_q;
        tmr_d  = tmr_q;
        qual   = 1'b0;
        target = cur;

        unique case (cur)
            ST_TC:   begin qual = (vbat_s >= vtok);    target = ST_CC;   end
            ST_CC:   begin qual = (vbat_s >= vcutoff); target = ST_CV;   end
            ST_CV:   begin qual = (ibat_s <= iend);    target = ST_DONE; end
            // Guarding the subtraction keeps a low vcutoff from wrapping
            // into a huge recharge level.
            ST_DONE: begin
                qual   = (vcutoff >= HYST_C) && (vbat_s < (vcutoff - HYST_C));
                target = ST_CC;
            end
            default: ;
        endcase

        if (!en) begin
            nxt   = ST_IDLE;
            deb_d = '0;
            tmr_d = '0;
        end else if (sample_valid) begin
            if (cur == ST_IDLE) begin
                nxt   = (vbat_s < vtok) ? ST_TC : (vbat_s < vcutoff) ? ST_CC : ST_CV;
                deb_d = '0;
                tmr_d = '0;
            end else if (cur != ST_FAULT) begin
                if (charging && tmr_q != 16'hFFFF) tmr_d = tmr_q + 16'd1;

                // Timeout is tested first so it wins over a threshold move.
                if (charging && tmax != 16'd0 && tmr_d >= tmax) begin
                    nxt   = ST_FAULT;
                    deb_d = '0;
                end else if (!qual) begin
                    deb_d = '0;
                end else if (32'(deb_q) + 1 >= DEB) begin
                    nxt   = target;
                    deb_d = '0;
                    if (target == ST_DONE) tmr_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= ST_IDLE;
            deb_q <= '0;
            tmr_q <= '0;
        end else begin
            cur   <= nxt;
            deb_q <= deb_d;
            tmr_q <= tmr_d;
        end
    end

    assign tc    = (cur == ST_TC);
    assign cc    = (cur == ST_CC);
    assign cv    = (cur == ST_CV);
    assign done  = (cur == ST_DONE);
    assign fault = (cur == ST_FAULT);
    assign state = cur;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Self-checking bench for batcharger_ctrl (SAMPLE_DIV=4, DEB=2, HYST=10).
module tb_batcharger_ctrl;

    localparam int SDIV = 4;
    localparam int DEBN = 2;
    localparam int HYS  = 10;

    localparam int M_IDLE = 0, M_TC = 1, M_CC = 2, M_CV = 3, M_DONE = 4, M_FAULT = 5;

    logic        clk = 1'b0;
    logic        rst, en, adc_ack;
    logic [7:0]  vbat, ibat, vtok, vcutoff, iend;
    logic [15:0] tmax;
    logic        adc_req, cc, tc, cv, done, fault;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit mon_fire = 1'b0;

    // Reference model: charging phase, streak of qualifying samples, samples spent charging.
    int m_mode, m_streak, m_timer;

    batcharger_ctrl #(.SAMPLE_DIV(SDIV), .DEB(DEBN), .HYST(HYS)) dut (
        .clk(clk), .rst(rst), .en(en), .vbat(vbat), .ibat(ibat), .vtok(vtok),
        .vcutoff(vcutoff), .iend(iend), .tmax(tmax), .adc_req(adc_req),
        .adc_ack(adc_ack), .cc(cc), .tc(tc), .cv(cv), .done(done),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mode_vec(input int m);
        return {m == M_TC, m == M_CC, m == M_CV, m == M_DONE, m == M_FAULT};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_streak = 0; m_timer = 0;
    endfunction

    // Applies one acknowledged sample to the model and returns the resulting phase.
    function automatic int model_step(input int vb, input int ib);
        int  vt = int'(vtok);
        int  vc = int'(vcutoff);
        bit  ok;
        int  goal;
        if (m_mode == M_IDLE) begin
            m_mode   = (vb < vt) ? M_TC : (vb < vc) ? M_CC : M_CV;
            m_streak = 0;
            m_timer  = 0;
            return m_mode;
        end
        if (m_mode == M_FAULT) return m_mode;
        if (m_mode != M_DONE) begin
            m_timer++;
            if (tmax != 0 && m_timer >= int'(tmax)) begin
                m_mode = M_FAULT;
                return m_mode;
            end
        end
        case (m_mode)
            M_TC:    begin ok = (vb >= vt);               goal = M_CC;   end
            M_CC:    begin ok = (vb >= vc);               goal = M_CV;   end
            M_CV:    begin ok = (ib <= int'(iend));       goal = M_DONE; end
            default: begin ok = (vb < vc - HYS);          goal = M_CC;   end
        endcase
        m_streak = ok ? m_streak + 1 : 0;
        if (m_streak >= DEBN) begin
            m_mode   = goal;
            m_streak = 0;
            if (goal == M_DONE) m_timer = 0;
        end
        return m_mode;
    endfunction

    // Waits (bounded) for a request, acknowledges it and queues the expected phase.
    task automatic do_sample(input int vb, input int ib, output int waited);
        int n = 0;
        while (adc_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (adc_req !== 1'b1) begin
            check("adc_req_timeout", 16'(adc_req), 16'd1);
            return;
        end
        vbat = 8'(vb); ibat = 8'(ib); adc_ack = 1'b1;
        exp_q.push_back(model_step(vb, ib));
        mon_fire = 1'b1;
        @(negedge clk);
        adc_ack = 1'b0; mon_fire = 1'b0;
    endtask

    task automatic drop_en();
        en = 1'b0;
        @(negedge clk);
        check("en_low_state", 16'(state), 16'(M_IDLE));
        check("en_low_req", 16'(adc_req), 16'd0);
        model_reset();
    endtask

    // Monitor: one clock after every counted acknowledge, compare against the queue.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            if (mon_fire) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 16'd1, 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("state", 16'(state), 16'(e));
                    check("modes", 16'({tc, cc, cv, done, fault}), 16'(mode_vec(e)));
                    check("req_after_ack", 16'(adc_req), 16'd0);
                end
            end
        end
    end

    initial begin
        int w;
        int vb, ib;
        int near_v[7] = '{152, 153, 177, 178, 187, 188, 189};

        rst = 1'b1; en = 1'b0; adc_ack = 1'b0; vbat = '0; ibat = '0;
        vtok = 8'd153; vcutoff = 8'd188; iend = 8'd25; tmax = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state", 16'(state), 16'd0);
        check("rst_outs", 16'({tc, cc, cv, done, fault, adc_req}), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Trickle start then CC; request spacing is SAMPLE_DIV cycles.
        en = 1'b1;
        do_sample(140, 100, w); check("div_from_en", 16'(w), 16'(SDIV));
        do_sample(160, 100, w); check("div_from_ack", 16'(w), 16'(SDIV));
        do_sample(160, 100, w);

        // Debounce restart in CC.
        do_sample(190, 100, w); do_sample(180, 100, w);
        do_sample(190, 100, w); do_sample(190, 100, w);

        // CV -> DONE, boundary 178 does not recharge, 177 does.
        do_sample(200, 20, w); do_sample(200, 20, w);
        do_sample(178, 0, w);  do_sample(178, 0, w);
        do_sample(177, 0, w);  do_sample(177, 0, w);

        // Enable dropped in the acknowledge cycle while in CC.
        while (adc_req !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        vbat = 8'd200; adc_ack = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        check("en_ack_state", 16'(state), 16'(M_IDLE));
        check("en_ack_req", 16'(adc_req), 16'd0);
        @(negedge clk);
        adc_ack = 1'b0;
        model_reset();

        // vcutoff below HYST: DONE never recharges.
        vcutoff = 8'd5; en = 1'b1;
        do_sample(200, 100, w); do_sample(200, 20, w); do_sample(200, 20, w);
        do_sample(0, 0, w); do_sample(0, 0, w); do_sample(0, 0, w);
        drop_en();
        vcutoff = 8'd188;

        // Randomised run with a timeout armed, stray acks and enable drops.
        tmax = 16'd20; en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            vb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                             : near_v[$urandom_range(0, 6)];
            ib = int'($urandom_range(10, 40));
            if ($urandom_range(0, 9) == 0 && adc_req === 1'b0) begin
                vbat = 8'($urandom_range(0, 255)); adc_ack = 1'b1;
                @(negedge clk);
                adc_ack = 1'b0;
            end
            do_sample(vb, ib, w);
            if ($urandom_range(0, 24) == 0) begin
                drop_en();
                en = 1'b1;
            end
        end
        drop_en();

        // Timeout: third counted sample in TC faults; only en=0 leaves FAULT.
        tmax = 16'd3; en = 1'b1;
        for (int i = 0; i < 5; i++) do_sample(140, 100, w);
        drop_en();
        tmax = 16'd0;

        // Reset while a request is pending, then a stray acknowledge.
        en = 1'b1;
        do_sample(140, 100, w);
        w = 0;
        while (adc_req !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        #1 rst = 1'b1;
        #1;
        check("rst_mid_state", 16'(state), 16'd0);
        check("rst_mid_outs", 16'({tc, cc, cv, done, fault, adc_req}), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vbat = 8'd200; adc_ack = 1'b1;
        @(negedge clk);
        adc_ack = 1'b0;
        check("stray_ack_state", 16'(state), 16'd0);
        check("stray_ack_req", 16'(adc_req), 16'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
